dmem_arbiter: RTL and testbench

Two-requester arbiter placed in front of the 8-bit data memory. It lets the core load/store unit (port A) and the DMA engine (port B) share the single-port memory. It owns the memory's enable, write-enable, address and write-data pins, grants one single-cycle access per clock with round-robin fairness, and returns registered read data to the granted requester.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_lock_cnt.sv | 35 +++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional lock feature is enabled by defining DMEM_ARB_LOCK_EN.
`timescale 1ns/1ps
package dmem_arb_pkg;

  // Arbiter FSM states; the OWN_x states decode directly into gnt_x.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  // Encoding of the round-robin "last owner" pointer.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // Default number of back-to-back grants a locking owner may hold.
  localparam int MAX_LOCK_DEFAULT = 4;

  // Width of the consecutive-grant counter (holds up to 15).
  localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_lock_cnt.sv
// Saturating consecutive-grant counter for the arbiter lock feature.
// Counts grants held by the current owner (including the present one) and
// raises o_release once that run reaches MAX_LOCK. Used only when
// DMEM_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module dmem_arb_lock_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,   // next state is an OWN state
  input  logic i_same,     // next owner equals current owner
  output logic o_release   // current owner has used up its lock budget
);

  logic [LOCK_CNT_W-1:0] r_cnt;

  // Track the length of the current ownership run; restart at 1 on a new owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_active) begin
      r_cnt <= '0;
    end else if (!i_same) begin
      r_cnt <= LOCK_CNT_W'(1);
    end else if (r_cnt != {LOCK_CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + LOCK_CNT_W'(1);
    end
  end

  assign o_release = (r_cnt >= LOCK_CNT_W'(MAX_LOCK));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port A (load/store unit) and port B (DMA) each get one access per grant
// cycle; read data comes back registered one cycle later.
// Define DMEM_ARB_LOCK_EN to add lock_a/lock_b and bounded back-to-back
// ownership (MAX_LOCK grants) under contention.
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
`ifdef DMEM_ARB_LOCK_EN
  parameter int MAX_LOCK = MAX_LOCK_DEFAULT,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] wdata_b,
`ifdef DMEM_ARB_LOCK_EN
  input  logic             lock_a,
  input  logic             lock_b,
`endif
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             mem_enable,
  output logic             mem_write_enable,
  output logic [AW-1:0]    mem_address,
  output logic [WIDTH-1:0] mem_data_in
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  owner_e     r_rr;          // last owner; decides ties
  logic       w_hold_a;      // A keeps ownership through contention
  logic       w_hold_b;      // B keeps ownership through contention

`ifdef DMEM_ARB_LOCK_EN
  logic w_release;
  logic w_active;
  logic w_same;

  assign w_active = (w_state_next != IDLE);
  assign w_same   = (w_state_next == r_state);

  dmem_arb_lock_cnt #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_active  (w_active),
    .i_same    (w_same),
    .o_release (w_release)
  );

  assign w_hold_a = (r_state == OWN_A) && req_a && lock_a && !w_release;
  assign w_hold_b = (r_state == OWN_B) && req_b && lock_b && !w_release;
`else
  assign w_hold_a = 1'b0;
  assign w_hold_b = 1'b0;
`endif

  // State register: reset drops any grant (and mem_enable) immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Round-robin pointer follows whoever is granted next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= OWNER_B;
    end else if (w_state_next == OWN_A) begin
      r_rr <= OWNER_A;
    end else if (w_state_next == OWN_B) begin
      r_rr <= OWNER_B;
    end
  end

  // Next-state: lock hold first, then tie-break against last owner, then single request.
  always_comb begin
    w_state_next = IDLE;
    if (w_hold_a) begin
      w_state_next = OWN_A;
    end else if (w_hold_b) begin
      w_state_next = OWN_B;
    end else if (req_a && req_b) begin
      w_state_next = (r_rr == OWNER_A) ? OWN_B : OWN_A;
    end else if (req_a) begin
      w_state_next = OWN_A;
    end else if (req_b) begin
      w_state_next = OWN_B;
    end
  end

  // Grant and memory pins decoded from the state register only.
  always_comb begin
    gnt_a            = 1'b0;
    gnt_b            = 1'b0;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    case (r_state)
      OWN_A: begin
        gnt_a            = 1'b1;
        mem_enable       = 1'b1;
        mem_write_enable = we_a;
        mem_address      = addr_a;
        mem_data_in      = wdata_a;
      end
      OWN_B: begin
        gnt_b            = 1'b1;
        mem_enable       = 1'b1;
        mem_write_enable = we_b;
        mem_address      = addr_b;
        mem_data_in      = wdata_b;
      end
      default: ;
    endcase
  end

  // Capture read data for the granted reader; rvalid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= (r_state == OWN_A) && !we_a;
      rvalid_b <= (r_state == OWN_B) && !we_b;
      if ((r_state == OWN_A) && !we_a) begin
        rdata_a <= mem_data_out;
      end
      if ((r_state == OWN_B) && !we_b) begin
        rdata_b <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a
// read-data scoreboard per port. Lock scenario runs when DMEM_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0]    addr_a = '0, addr_b = '0;
  logic [WIDTH-1:0] wdata_a = '0, wdata_b = '0;
  logic             lock_a = 1'b0, lock_b = 1'b0;
  logic [WIDTH-1:0] mem_data_out;
  logic             gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             mem_enable, mem_write_enable;
  logic [AW-1:0]    mem_address;
  logic [WIDTH-1:0] mem_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] exp_mem [DEPTH];
  logic             mem_init = 1'b1;
  logic [WIDTH-1:0] qa [$];
  logic [WIDTH-1:0] qb [$];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_a            (req_a),
    .we_a             (we_a),
    .addr_a           (addr_a),
    .wdata_a          (wdata_a),
    .req_b            (req_b),
    .we_b             (we_b),
    .addr_b           (addr_b),
    .wdata_b          (wdata_b),
`ifdef DMEM_ARB_LOCK_EN
    .lock_a           (lock_a),
    .lock_b           (lock_b),
`endif
    .mem_data_out     (mem_data_out),
    .gnt_a            (gnt_a),
    .gnt_b            (gnt_b),
    .rvalid_a         (rvalid_a),
    .rvalid_b         (rvalid_b),
    .rdata_a          (rdata_a),
    .rdata_b          (rdata_b),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in)
  );

  function automatic logic [WIDTH-1:0] init_val(input int i);
    return WIDTH'(8'hA0 + i);
  endfunction

  // Behavioural single-port memory: async read, write on rising edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (mem_enable && mem_write_enable) begin
      mem[mem_address] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_address];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every rvalid pops the oldest expected read for that port.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid_a) begin
        if (qa.size() == 0) check_val("rvalid_a_unexpected", 1, 0);
        else begin
          logic [WIDTH-1:0] e;
          e = qa.pop_front();
          $display("rd A data=%02h exp=%02h", rdata_a, e);
          check_val("rdata_a", rdata_a, e);
        end
      end
      if (rvalid_b) begin
        if (qb.size() == 0) check_val("rvalid_b_unexpected", 1, 0);
        else begin
          logic [WIDTH-1:0] e;
          e = qb.pop_front();
          $display("rd B data=%02h exp=%02h", rdata_b, e);
          check_val("rdata_b", rdata_b, e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_val(i);

    // Reset: a request during reset must not be granted.
    req_a = 1'b1;
    @(posedge clk);
    #1 mem_init = 1'b0;
    sample();
    check_val("rst_gnt_a", gnt_a, 0);
    check_val("rst_gnt_b", gnt_b, 0);
    check_val("rst_mem_en", mem_enable, 0);
    check_val("rst_mem_addr", mem_address, 0);
    check_val("rst_rvalid_a", rvalid_a, 0);
    check_val("rst_rdata_b", rdata_b, 0);
    req_a = 1'b0;
    #2 rst_n = 1'b1;

    // Single write from A, then read back from B.
    step();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'h5A; exp_mem[3] = 8'h5A;
    sample();
    check_val("t1_c0_gnt_a", gnt_a, 0);
    step();
    req_a = 1'b0;
    sample();
    check_val("t1_c1_gnt_a", gnt_a, 1);
    check_val("t1_mem_en", mem_enable, 1);
    check_val("t1_mem_we", mem_write_enable, 1);
    check_val("t1_mem_addr", mem_address, 3);
    check_val("t1_mem_din", mem_data_in, 8'h5A);
    step();
    we_a = 1'b0;
    sample();
    check_val("t1_c2_gnt_a", gnt_a, 0);
    check_val("t1_mem3", mem[3], exp_mem[3]);
    step();
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd3; qb.push_back(exp_mem[3]);
    sample();
    check_val("t1b_c0_gnt_b", gnt_b, 0);
    step();
    req_b = 1'b0;
    sample();
    check_val("t1b_c1_gnt_b", gnt_b, 1);
    check_val("t1b_mem_we", mem_write_enable, 0);
    step();
    sample();
    check_val("t1b_c2_rvalid_b", rvalid_b, 1);
    check_val("t1b_c2_rdata_b", rdata_b, 8'h5A);

    // Both ports stream reads: strict alternation starting with A.
    step();
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd5;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd9;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(exp_mem[5]);
      qb.push_back(exp_mem[9]);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) req_a = 1'b0;
      if (k == 6) req_b = 1'b0;
      sample();
      check_val($sformatf("t2_gnt_a_c%0d", k), gnt_a, (k <= 5) && (k % 2 == 1));
      check_val($sformatf("t2_gnt_b_c%0d", k), gnt_b, (k <= 6) && (k % 2 == 0));
      check_val($sformatf("t2_rvalid_a_c%0d", k), rvalid_a, (k >= 2) && (k <= 6) && (k % 2 == 0));
      check_val($sformatf("t2_rvalid_b_c%0d", k), rvalid_b, (k >= 3) && (k % 2 == 1));
    end

    // B alone streams four writes to addresses 0..3.
    step();
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd0; wdata_b = 8'hC0; exp_mem[0] = 8'hC0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2 && k <= 4) begin
        addr_b = AW'(k - 1);
        wdata_b = WIDTH'(8'hC0 + k - 1);
        exp_mem[k - 1] = WIDTH'(8'hC0 + k - 1);
      end
      if (k == 4) req_b = 1'b0;
      if (k == 5) we_b = 1'b0;
      sample();
      check_val($sformatf("t3_gnt_b_c%0d", k), gnt_b, k <= 4);
      if (k <= 4) check_val($sformatf("t3_addr_c%0d", k), mem_address, k - 1);
      else check_val("t3_idle_mem_en", mem_enable, 0);
    end
    for (int i = 0; i < 4; i++) check_val($sformatf("t3_mem%0d", i), mem[i], exp_mem[i]);

`ifdef DMEM_ARB_LOCK_EN
    // A locks while B waits: four A grants, one B, then A again.
    step();
    req_a = 1'b1; lock_a = 1'b1; we_a = 1'b0; addr_a = 4'd2;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd4;
    for (int i = 0; i < 5; i++) qa.push_back(exp_mem[2]);
    qb.push_back(exp_mem[4]);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) req_b = 1'b0;
      if (k == 6) begin
        req_a = 1'b0;
        lock_a = 1'b0;
      end
      sample();
      check_val($sformatf("lk_gnt_a_c%0d", k), gnt_a, (k <= 4) || (k == 6));
      check_val($sformatf("lk_gnt_b_c%0d", k), gnt_b, k == 5);
    end
`endif

    // Reset asserted mid-grant of a write must suppress it.
    step();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; wdata_a = 8'hFF;
    step();
    #1;
    check_val("rs_gnt_a_before", gnt_a, 1);
    rst_n = 1'b0;
    #1;
    check_val("rs_gnt_a_async", gnt_a, 0);
    check_val("rs_mem_en_async", mem_enable, 0);
    req_a = 1'b0; we_a = 1'b0;
    @(posedge clk);
    #1;
    check_val("rs_mem7", mem[7], exp_mem[7]);
    #2 rst_n = 1'b1;
    step();
    sample();
    check_val("rs_idle_gnt_a", gnt_a, 0);
    check_val("rs_idle_gnt_b", gnt_b, 0);
    check_val("rs_idle_mem_en", mem_enable, 0);

    // A reads DEPTH-1 while B writes addr 0; A wins the first tie after reset.
    step();
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd15; qa.push_back(exp_mem[15]);
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd0; wdata_b = 8'h3C; exp_mem[0] = 8'h3C;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) req_a = 1'b0;
      if (k == 2) req_b = 1'b0;
      sample();
      check_val($sformatf("t6_gnt_a_c%0d", k), gnt_a, k == 1);
      check_val($sformatf("t6_gnt_b_c%0d", k), gnt_b, k == 2);
      if (k == 1) check_val("t6_addr_a", mem_address, 15);
      if (k == 2) check_val("t6_addr_b", mem_address, 0);
    end
    check_val("t6_mem0", mem[0], exp_mem[0]);
    step();
    we_b = 1'b0; req_b = 1'b1; addr_b = 4'd0; qb.push_back(exp_mem[0]);
    step();
    req_b = 1'b0;
    step();
    step();
    step();
    sample();
    check_val("end_qa_empty", qa.size(), 0);
    check_val("end_qb_empty", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
